axi_rd_arbiter_rr: RTL and testbench
====================================

Name: axi_rd_arbiter_rr

Overview:
- Parametrised N-master to 1-slave AXI read-path arbiter. Generalises the fixed two-master address arbitration in the AXI top to NUM_M masters.
- Arbitration is round-robin. A registered AR slice sits toward the slave. The master index is prepended to ARID.
- The grant is held until the whole R burst completes (RLAST handshake). A beat counter checks the slave's RLAST against ARLEN.
- One instance sits per slave read port inside the interconnect.

Parameters:
- NUM_M, 2, number of masters (2..8); IDX_BITS = $clog2(NUM_M) is a localparam.
- IDM_BITS, 4, master-side ID width; slave-side ID width is IDS_BITS = IDM_BITS+IDX_BITS.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width.
- LEN_BITS, 4, ARLEN width.
- SIZE_BITS, 3, ARSIZE width.

Ports:
- ACLK in 1 clock.
- ARESETn in 1 synchronous active-low reset.
- ARID_M in NUM_M*IDM_BITS packed master ARIDs (master k at slice k).
- ARADDR_M in NUM_M*ADDR_BITS.
- ARLEN_M in NUM_M*LEN_BITS.
- ARSIZE_M in NUM_M*SIZE_BITS.
- ARBURST_M in NUM_M*2.
- ARVALID_M in NUM_M.
- ARREADY_M out NUM_M.
- RID_M out IDM_BITS, shared by all masters.
- RDATA_M out DATA_BITS, shared.
- RRESP_M out 2, shared.
- RLAST_M out 1, shared.
- RVALID_M out NUM_M, one-hot.
- RREADY_M in NUM_M.
- ARID_S out IDS_BITS.
- ARADDR_S out ADDR_BITS.
- ARLEN_S out LEN_BITS.
- ARSIZE_S out SIZE_BITS.
- ARBURST_S out 2.
- ARVALID_S out 1.
- ARREADY_S in 1.
- RID_S in IDS_BITS.
- RDATA_S in DATA_BITS.
- RRESP_S in 2.
- RLAST_S in 1.
- RVALID_S in 1.
- RREADY_S out 1.
- prot_err out 1, one-cycle pulse on a burst-length mismatch.

Behaviour:
- Single clock ACLK; reset is synchronous, active-low on ARESETn, sampled on the ACLK rising edge. It overrides all other activity, including mid-burst.
- Reset values:
  - State IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - AR payload registers 0; ARVALID_S=0, RREADY_S=0, all RVALID_M=0, ARREADY_M=0, prot_err=0.
  - Shared R outputs are 0 while not in DATA.
- State IDLE:
  - Candidate is the first k with ARVALID_M[k]=1, searched from rr_ptr upward modulo NUM_M.
  - If a candidate exists, ARREADY_M[k]=1 that cycle (combinational, at most one bit set), which completes the master AR handshake.
  - The same edge captures the payload: ARID_S={k[IDX_BITS-1:0], ARID_M slice k}, plus ADDR/LEN/SIZE/BURST. It also sets grant=k and moves to ADDR.
  - No candidate: stay in IDLE, all ARREADY_M=0.
- State ADDR:
  - ARVALID_S=1 with the registered payload held stable; ARREADY_M all 0.
  - On ARREADY_S=1 the next state is DATA and beat_cnt is cleared to 0.
  - Latency: the master handshake at cycle T gives ARVALID_S=1 at T+1. ARVALID_S must never drop before ARREADY_S.
- State DATA:
  - RVALID_M[grant]=RVALID_S (other bits 0) and RREADY_S=RREADY_M[grant].
  - RDATA_M/RRESP_M/RLAST_M pass through; RID_M=RID_S[IDM_BITS-1:0].
  - On each beat (RVALID_S&RREADY_S), beat_cnt increments, saturating at 2^LEN_BITS.
  - On a beat with RLAST_S=1 the next state is IDLE and rr_ptr=(grant+1) mod NUM_M.
  - prot_err pulses the cycle after a last beat whose beat_cnt+1 != ARLEN_S+1. It also pulses after a non-last beat where beat_cnt+1 == ARLEN_S+1 (the slave is late); that case flags once and the grant stays held until RLAST_S.
  - RID_S upper bits are not checked.
- Path rules:
  - No combinational path from ARREADY_S to any ARREADY_M.
  - R path is combinational pass-through, zero added latency.
- Fairness: a continuously requesting master waits at most NUM_M-1 bursts.
- Simultaneous events:
  - A new request arriving while in ADDR or DATA waits (ARREADY_M=0).
  - The IDLE re-entry cycle arbitrates immediately, giving a 1-cycle bubble between bursts.
- Reset during DATA abandons the burst: RREADY_S and RVALID_M drop the next cycle.

Test Plan:
- Reset: hold ARESETn=0 for 3 cycles with ARVALID_M=2'b11 -> all ARREADY_M, ARVALID_S, RREADY_S, RVALID_M and prot_err stay 0; the first grant after release goes to M0.
- Single read, NUM_M=2: M1 issues ARID=4'h3, ARADDR=0x1000_0040, ARLEN=3 at cycle T -> ARREADY_M=2'b10 at T, and at T+1 ARVALID_S=1 with ARID_S=5'h13. Four slave beats with RID_S=5'h13 and RLAST on the 4th reach only M1, with RID_M=4'h3 and prot_err=0.
- Round-robin: M0 and M1 both hold ARVALID continuously for 4 bursts of ARLEN=0 -> grant order M0,M1,M0,M1, with exactly one IDLE bubble cycle between bursts.
- Backpressure: ARREADY_S=0 for 5 cycles -> ARVALID_S and the payload stay stable. Then RREADY_M[grant]=0 on beat 2 -> RREADY_S=0 and RDATA_M holds until RREADY_M rises.
- Length mismatch: ARLEN=3 with the slave asserting RLAST on beat 2 -> the burst ends and prot_err=1 for exactly one cycle. A second case with ARLEN=1 and RLAST on beat 4 -> prot_err pulses after beat 2 and the grant releases only after beat 4.
- Mid-burst reset: ARESETn=0 during beat 2 of ARLEN=7 -> all outputs return to reset values next edge; after release a fresh M1 request is granted with rr_ptr=0 priority.

Source files
------------

// File: rtl/axi_rd_arbiter_rr_if.sv
// Read-path bundle between NUM_M AXI masters, the round-robin arbiter and one slave port.
// The master modport is the arbiter's view; slave is the surrounding fabric's view.
interface axi_rd_arbiter_rr_if #(
  parameter int NUM_M     = 2,
  parameter int IDM_BITS  = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
);
  localparam int IDX_BITS = $clog2(NUM_M);
  localparam int IDS_BITS = IDM_BITS + IDX_BITS;

  logic [NUM_M*IDM_BITS-1:0]  ARID_M;
  logic [NUM_M*ADDR_BITS-1:0] ARADDR_M;
  logic [NUM_M*LEN_BITS-1:0]  ARLEN_M;
  logic [NUM_M*SIZE_BITS-1:0] ARSIZE_M;
  logic [NUM_M*2-1:0]         ARBURST_M;
  logic [NUM_M-1:0]           ARVALID_M;
  logic [NUM_M-1:0]           ARREADY_M;
  logic [IDM_BITS-1:0]        RID_M;
  logic [DATA_BITS-1:0]       RDATA_M;
  logic [1:0]                 RRESP_M;
  logic                       RLAST_M;
  logic [NUM_M-1:0]           RVALID_M;
  logic [NUM_M-1:0]           RREADY_M;

  logic [IDS_BITS-1:0]        ARID_S;
  logic [ADDR_BITS-1:0]       ARADDR_S;
  logic [LEN_BITS-1:0]        ARLEN_S;
  logic [SIZE_BITS-1:0]       ARSIZE_S;
  logic [1:0]                 ARBURST_S;
  logic                       ARVALID_S;
  logic                       ARREADY_S;
  logic [IDS_BITS-1:0]        RID_S;
  logic [DATA_BITS-1:0]       RDATA_S;
  logic [1:0]                 RRESP_S;
  logic                       RLAST_S;
  logic                       RVALID_S;
  logic                       RREADY_S;

  modport master (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );

  modport slave (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
  );
endinterface

// File: rtl/axi_rd_arbiter_rr.sv
// Round-robin N:1 AXI read arbiter: registered AR slice toward the slave, grant held
// for the whole R burst, master index prepended to ARID, RLAST checked against ARLEN.
module axi_rd_arbiter_rr #(
  parameter int NUM_M     = 2,
  parameter int IDM_BITS  = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_rd_arbiter_rr_if.master  bus,
  output logic                 prot_err
);
  localparam int IDX_BITS = $clog2(NUM_M);
  localparam int IDS_BITS = IDM_BITS + IDX_BITS;
  localparam int CNT_BITS = LEN_BITS + 1;
  localparam logic [CNT_BITS-1:0]  CNT_MAX = CNT_BITS'(1) << LEN_BITS;
  localparam logic [IDX_BITS-1:0]  LAST_M  = IDX_BITS'(NUM_M - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_nxt;
  logic [IDX_BITS-1:0]   rr_ptr, grant, cand, idx;
  logic                  found;
  logic [CNT_BITS-1:0]   beat_cnt;
  logic                  late_flag;
  logic [CNT_BITS:0]     beat_num, len_num;
  logic                  beat;

  logic [IDS_BITS-1:0]   arid_q;
  logic [ADDR_BITS-1:0]  araddr_q;
  logic [LEN_BITS-1:0]   arlen_q;
  logic [SIZE_BITS-1:0]  arsize_q;
  logic [1:0]            arburst_q;
  logic                  unused_rid_hi;

  // Walk NUM_M slots starting at rr_ptr, wrapping at the last master.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && bus.ARVALID_M[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
      idx = (idx == LAST_M) ? '0 : idx + 1'b1;
    end
  end

  assign beat     = (state == DATA) & bus.RVALID_S & bus.RREADY_M[grant];
  assign beat_num = {1'b0, beat_cnt} + 1'b1;
  assign len_num  = {2'b00, arlen_q} + 1'b1;

  assign bus.ARID_S    = arid_q;
  assign bus.ARADDR_S  = araddr_q;
  assign bus.ARLEN_S   = arlen_q;
  assign bus.ARSIZE_S  = arsize_q;
  assign bus.ARBURST_S = arburst_q;
  assign unused_rid_hi = ^bus.RID_S[IDS_BITS-1:IDM_BITS];

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    state_nxt     = state;
    bus.ARREADY_M = '0;
    bus.ARVALID_S = 1'b0;
    bus.RVALID_M  = '0;
    bus.RREADY_S  = 1'b0;
    bus.RID_M     = '0;
    bus.RDATA_M   = '0;
    bus.RRESP_M   = '0;
    bus.RLAST_M   = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          // Gated so that no master sees a handshake while reset is asserted.
          bus.ARREADY_M[cand] = ARESETn;
          state_nxt           = ADDR;
        end
      end
      ADDR: begin
        bus.ARVALID_S = 1'b1;
        if (bus.ARREADY_S) state_nxt = DATA;
      end
      DATA: begin
        bus.RVALID_M[grant] = bus.RVALID_S;
        bus.RREADY_S        = bus.RREADY_M[grant];
        bus.RID_M           = bus.RID_S[IDM_BITS-1:0];
        bus.RDATA_M         = bus.RDATA_S;
        bus.RRESP_M         = bus.RRESP_S;
        bus.RLAST_M         = bus.RLAST_S;
        if (beat && bus.RLAST_S) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      late_flag <= 1'b0;
      prot_err  <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      prot_err <= 1'b0;
      if (state == IDLE && found) begin
        grant     <= cand;
        arid_q    <= {cand, bus.ARID_M[cand*IDM_BITS +: IDM_BITS]};
        araddr_q  <= bus.ARADDR_M[cand*ADDR_BITS +: ADDR_BITS];
        arlen_q   <= bus.ARLEN_M[cand*LEN_BITS +: LEN_BITS];
        arsize_q  <= bus.ARSIZE_M[cand*SIZE_BITS +: SIZE_BITS];
        arburst_q <= bus.ARBURST_M[cand*2 +: 2];
      end
      if (state == ADDR && bus.ARREADY_S) begin
        beat_cnt  <= '0;
        late_flag <= 1'b0;
      end
      if (beat) begin
        if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + 1'b1;
        if (bus.RLAST_S) begin
          // A burst already flagged as late is not flagged a second time at RLAST.
          prot_err <= (beat_num != len_num) && !late_flag;
          rr_ptr   <= (grant == LAST_M) ? '0 : grant + 1'b1;
        end else if (beat_num == len_num) begin
          prot_err  <= 1'b1;
          late_flag <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter_rr.sv
// Self-checking bench for axi_rd_arbiter_rr: directed scenarios plus randomized bursts
// checked against a transaction-level round-robin and burst-length model.
module tb_axi_rd_arbiter_rr;
  localparam int NUM_M     = 2;
  localparam int IDM_BITS  = 4;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int LEN_BITS  = 4;
  localparam int SIZE_BITS = 3;
  localparam int IDX_BITS  = $clog2(NUM_M);
  localparam int IDS_BITS  = IDM_BITS + IDX_BITS;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic prot_err;

  axi_rd_arbiter_rr_if #(
    .NUM_M(NUM_M), .IDM_BITS(IDM_BITS), .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS)
  ) bus ();

  axi_rd_arbiter_rr #(
    .NUM_M(NUM_M), .IDM_BITS(IDM_BITS), .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS), .SIZE_BITS(SIZE_BITS)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus),
    .prot_err(prot_err)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  logic [IDM_BITS-1:0]  p_id    [NUM_M];
  logic [ADDR_BITS-1:0] p_addr  [NUM_M];
  logic [LEN_BITS-1:0]  p_len   [NUM_M];
  logic [SIZE_BITS-1:0] p_size  [NUM_M];
  logic [1:0]           p_burst [NUM_M];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NUM_M; k++) begin
      p_id[k]    = IDM_BITS'($urandom);
      p_addr[k]  = ADDR_BITS'($urandom);
      p_len[k]   = LEN_BITS'($urandom_range(7));
      p_size[k]  = SIZE_BITS'($urandom_range(2));
      p_burst[k] = 2'($urandom_range(2));
    end
  endtask

  task automatic drive_ar(input logic [NUM_M-1:0] req);
    for (int k = 0; k < NUM_M; k++) begin
      bus.ARID_M[k*IDM_BITS +: IDM_BITS]     = p_id[k];
      bus.ARADDR_M[k*ADDR_BITS +: ADDR_BITS] = p_addr[k];
      bus.ARLEN_M[k*LEN_BITS +: LEN_BITS]    = p_len[k];
      bus.ARSIZE_M[k*SIZE_BITS +: SIZE_BITS] = p_size[k];
      bus.ARBURST_M[k*2 +: 2]                = p_burst[k];
    end
    bus.ARVALID_M = req;
  endtask

  // Model: the first requester at or after the pointer, modulo NUM_M, wins.
  function automatic int rr_pick(input logic [NUM_M-1:0] req);
    for (int i = 0; i < NUM_M; i++) begin
      if (req[(m_ptr + i) % NUM_M]) return (m_ptr + i) % NUM_M;
    end
    return 0;
  endfunction

  // One complete burst. Entered in an IDLE cycle just after a clock edge; returns in the
  // bubble cycle after the last beat. mode 0: no gaps, 1: random gaps, 2: stall on beat 2.
  task automatic do_burst(input logic [NUM_M-1:0] req, input int last_at, input int ar_wait,
                          input int mode, output logic [NUM_M-1:0] seen);
    logic [IDX_BITS-1:0]  wi;
    logic [NUM_M-1:0]     onehot;
    logic [IDS_BITS-1:0]  exp_id;
    logic [DATA_BITS-1:0] d;
    logic [1:0]           resp;
    int  beats, cyc, stall, len1;
    bit  done, hold, rv, rr, rl, exp_perr, perr_next, flagged;

    drive_ar(req);
    bus.ARREADY_S = 1'b0;
    bus.RVALID_S  = 1'b0;
    bus.RLAST_S   = 1'b0;
    bus.RREADY_M  = '0;
    settle();
    wi     = IDX_BITS'(rr_pick(req));
    onehot = NUM_M'(1) << wi;
    exp_id = {wi, p_id[wi]};
    len1   = int'(p_len[wi]) + 1;
    seen   = bus.ARREADY_M;
    total++;
    if (bus.ARREADY_M !== onehot) begin
      bad++;
      $display("FAIL ar_grant: ARREADY_M=%b expected %b", bus.ARREADY_M, onehot);
    end

    for (int c = 0; c <= ar_wait; c++) begin
      step();
      bus.ARVALID_M = req & ~onehot;
      bus.ARREADY_S = (c == ar_wait);
      settle();
      total++;
      if (bus.ARVALID_S !== 1'b1 || bus.ARID_S !== exp_id || bus.ARADDR_S !== p_addr[wi] ||
          bus.ARLEN_S !== p_len[wi] || bus.ARSIZE_S !== p_size[wi] || bus.ARBURST_S !== p_burst[wi]) begin
        bad++;
        $display("FAIL ar_slice: valid=%b id=%h addr=%h len=%h expected valid=1 id=%h addr=%h len=%h",
                 bus.ARVALID_S, bus.ARID_S, bus.ARADDR_S, bus.ARLEN_S, exp_id, p_addr[wi], p_len[wi]);
      end
      total++;
      if (bus.ARREADY_M !== '0) begin
        bad++;
        $display("FAIL ar_wait_busy: ARREADY_M=%b expected 0", bus.ARREADY_M);
      end
    end

    step();
    bus.ARREADY_S = 1'b0;
    beats = 0; cyc = 0; stall = 0;
    done = 0; hold = 0; exp_perr = 0; flagged = 0;
    rv = 0; rl = 0; d = '0; resp = '0;
    while (!done) begin
      if (!hold) begin
        rv   = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
        d    = DATA_BITS'($urandom);
        resp = 2'($urandom_range(3));
        rl   = rv && (beats + 1 == last_at);
      end
      rr = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      if (mode == 2 && beats == 1 && stall < 3) begin
        rr = 1'b0;
        stall++;
      end
      bus.RVALID_S = rv;
      bus.RDATA_S  = d;
      bus.RRESP_S  = resp;
      bus.RLAST_S  = rl;
      bus.RID_S    = exp_id;
      bus.RREADY_M = (NUM_M'($urandom) & ~onehot) | (rr ? onehot : '0);
      settle();
      total++;
      if (prot_err !== exp_perr) begin
        bad++;
        $display("FAIL prot_err: got %b expected %b after beat %0d", prot_err, exp_perr, beats);
      end
      total++;
      if (bus.RVALID_M !== (rv ? onehot : '0) || bus.RREADY_S !== rr) begin
        bad++;
        $display("FAIL r_route: RVALID_M=%b RREADY_S=%b expected %b %b",
                 bus.RVALID_M, bus.RREADY_S, (rv ? onehot : '0), rr);
      end
      total++;
      if (bus.ARREADY_M !== '0 || bus.ARVALID_S !== 1'b0) begin
        bad++;
        $display("FAIL data_busy: ARREADY_M=%b ARVALID_S=%b expected 0 0", bus.ARREADY_M, bus.ARVALID_S);
      end
      if (rv) begin
        total++;
        if (bus.RDATA_M !== d || bus.RRESP_M !== resp || bus.RLAST_M !== rl || bus.RID_M !== p_id[wi]) begin
          bad++;
          $display("FAIL r_data: data=%h resp=%b last=%b id=%h expected %h %b %b %h",
                   bus.RDATA_M, bus.RRESP_M, bus.RLAST_M, bus.RID_M, d, resp, rl, p_id[wi]);
        end
      end
      perr_next = 0;
      if (rv && rr) begin
        beats++;
        if (rl) begin
          perr_next = (beats != len1) && !flagged;
          done      = 1;
        end else if (beats == len1) begin
          perr_next = 1;
          flagged   = 1;
        end
        hold = 0;
      end else begin
        hold = rv;
      end
      cyc++;
      if (cyc > 300) begin
        total++;
        bad++;
        $display("FAIL burst_timeout: beats=%0d expected last at %0d", beats, last_at);
        done = 1;
      end
      step();
      exp_perr = perr_next;
    end

    bus.ARVALID_M = '0;
    bus.RVALID_S  = 1'b0;
    bus.RLAST_S   = 1'b0;
    bus.RREADY_M  = '0;
    settle();
    total++;
    if (prot_err !== exp_perr) begin
      bad++;
      $display("FAIL prot_err_end: got %b expected %b", prot_err, exp_perr);
    end
    total++;
    if (bus.ARVALID_S !== 1'b0 || bus.RVALID_M !== '0 || bus.RREADY_S !== 1'b0 || bus.RDATA_M !== '0) begin
      bad++;
      $display("FAIL bubble: ARVALID_S=%b RVALID_M=%b RREADY_S=%b RDATA_M=%h expected all 0",
               bus.ARVALID_S, bus.RVALID_M, bus.RREADY_S, bus.RDATA_M);
    end
    m_ptr = (int'(wi) + 1) % NUM_M;
  endtask

  task automatic test_reset();
    rand_payload();
    drive_ar(2'b11);
    bus.ARREADY_S = 1'b1;
    bus.RVALID_S  = 1'b1;
    bus.RLAST_S   = 1'b1;
    bus.RREADY_M  = '1;
    bus.RDATA_S   = 32'hdead_beef;
    bus.RRESP_S   = 2'b00;
    bus.RID_S     = '0;
    ARESETn       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      total++;
      if (bus.ARREADY_M !== '0 || bus.ARVALID_S !== 1'b0 || bus.RREADY_S !== 1'b0 ||
          bus.RVALID_M !== '0 || prot_err !== 1'b0 || bus.RDATA_M !== '0) begin
        bad++;
        $display("FAIL reset_hold: ARREADY_M=%b ARVALID_S=%b RREADY_S=%b RVALID_M=%b prot_err=%b expected all 0",
                 bus.ARREADY_M, bus.ARVALID_S, bus.RREADY_S, bus.RVALID_M, prot_err);
      end
    end
    ARESETn       = 1'b1;
    bus.ARREADY_S = 1'b0;
    bus.RVALID_S  = 1'b0;
    bus.RLAST_S   = 1'b0;
    bus.RREADY_M  = '0;
    settle();
    total++;
    if (bus.ARREADY_M !== 2'b01) begin
      bad++;
      $display("FAIL reset_first_grant: ARREADY_M=%b expected 01", bus.ARREADY_M);
    end
    bus.ARVALID_M = '0;
    m_ptr = 0;
    step();
  endtask

  task automatic test_single_read();
    logic [NUM_M-1:0] seen;
    rand_payload();
    p_id[1] = 4'h3; p_addr[1] = 32'h1000_0040; p_len[1] = 4'd3;
    p_size[1] = 3'd2; p_burst[1] = 2'b01;
    do_burst(2'b10, 4, 0, 0, seen);
  endtask

  task automatic test_round_robin();
    logic [NUM_M-1:0] seen;
    int order [4] = '{0, 1, 0, 1};
    rand_payload();
    for (int k = 0; k < NUM_M; k++) p_len[k] = '0;
    for (int i = 0; i < 4; i++) begin
      do_burst(2'b11, 1, 0, 0, seen);
      total++;
      if (seen !== (NUM_M'(1) << order[i])) begin
        bad++;
        $display("FAIL rr_order: burst %0d ARREADY_M=%b expected M%0d", i, seen, order[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [NUM_M-1:0] seen;
    rand_payload();
    p_len[0] = 4'd3;
    do_burst(2'b01, 4, 5, 2, seen);
  endtask

  task automatic test_len_mismatch();
    logic [NUM_M-1:0] seen;
    rand_payload();
    p_len[1] = 4'd3;
    do_burst(2'b10, 2, 0, 0, seen);
    step();
    settle();
    total++;
    if (prot_err !== 1'b0) begin
      bad++;
      $display("FAIL prot_err_width: got %b expected 0 two cycles after early RLAST", prot_err);
    end
    rand_payload();
    for (int k = 0; k < NUM_M; k++) p_len[k] = 4'd1;
    do_burst(2'b11, 4, 1, 0, seen);
  endtask

  task automatic test_mid_burst_reset();
    logic [NUM_M-1:0]    seen;
    logic [IDS_BITS-1:0] id1;
    rand_payload();
    do_burst(2'b01, int'(p_len[0]) + 1, 0, 0, seen);
    p_len[1] = 4'd7;
    id1 = {IDX_BITS'(1), p_id[1]};
    drive_ar(2'b10);
    settle();
    total++;
    if (bus.ARREADY_M !== 2'b10) begin
      bad++;
      $display("FAIL mid_grant: ARREADY_M=%b expected 10", bus.ARREADY_M);
    end
    step();
    bus.ARVALID_M = '0;
    bus.ARREADY_S = 1'b1;
    step();
    bus.ARREADY_S = 1'b0;
    bus.RVALID_S  = 1'b1;
    bus.RLAST_S   = 1'b0;
    bus.RDATA_S   = 32'h0000_0001;
    bus.RID_S     = id1;
    bus.RREADY_M  = '1;
    step();
    bus.RDATA_S   = 32'h0000_0002;
    ARESETn       = 1'b0;
    settle();
    total++;
    if (bus.RVALID_M !== 2'b10 || bus.RREADY_S !== 1'b1) begin
      bad++;
      $display("FAIL mid_beat2: RVALID_M=%b RREADY_S=%b expected 10 1", bus.RVALID_M, bus.RREADY_S);
    end
    step();
    settle();
    total++;
    if (bus.RVALID_M !== '0 || bus.RREADY_S !== 1'b0 || bus.ARVALID_S !== 1'b0 || prot_err !== 1'b0 ||
        bus.RDATA_M !== '0 || bus.ARID_S !== '0 || bus.ARADDR_S !== '0 || bus.ARLEN_S !== '0) begin
      bad++;
      $display("FAIL mid_reset: RVALID_M=%b RREADY_S=%b ARVALID_S=%b prot_err=%b RDATA_M=%h ARID_S=%h expected all 0",
               bus.RVALID_M, bus.RREADY_S, bus.ARVALID_S, prot_err, bus.RDATA_M, bus.ARID_S);
    end
    ARESETn      = 1'b1;
    bus.RVALID_S = 1'b0;
    bus.RREADY_M = '0;
    m_ptr        = 0;
    rand_payload();
    do_burst(2'b11, int'(p_len[0]) + 1, 0, 0, seen);
    total++;
    if (seen !== 2'b01) begin
      bad++;
      $display("FAIL mid_ptr_reset: ARREADY_M=%b expected 01", seen);
    end
    do_burst(2'b10, int'(p_len[1]) + 1, 0, 0, seen);
  endtask

  task automatic test_random();
    logic [NUM_M-1:0] seen;
    logic [NUM_M-1:0] req;
    int last_at, w;
    for (int n = 0; n < 40; n++) begin
      rand_payload();
      do req = NUM_M'($urandom); while (req == '0);
      w = rr_pick(req);
      last_at = int'(p_len[w]) + 1;
      if ($urandom_range(3) == 0) last_at = $urandom_range(int'(p_len[w]) + 3, 1);
      do_burst(req, last_at, $urandom_range(3), 1, seen);
    end
  endtask

  initial begin
    bus.ARVALID_M = '0;
    bus.RREADY_M  = '0;
    bus.ARREADY_S = 1'b0;
    bus.RVALID_S  = 1'b0;
    bus.RLAST_S   = 1'b0;
    bus.RID_S     = '0;
    bus.RDATA_S   = '0;
    bus.RRESP_S   = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_pressure();
    test_len_mismatch();
    test_mid_burst_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
